serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_ctrl_full_adder.sv | 14 +
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default operand width for serial_adder_ctrl.
package serial_adder_pkg;

    localparam int DATA_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// full_adder: single-bit combinational full adder, the only arithmetic on the serial datapath.
// Ports: a, b, ci -> s (sum bit), co (carry out).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder {out_co,out_s} = in_a + in_b + in_ci, LSB first, one bit per clock.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_a, in_b, in_ci        operands and carry-in, captured when in_vld & in_rd
//   in_vld / in_rd           request handshake (in_rd high only in IDLE)
//   out_s, out_co            result, held until the next completion
//   out_vld / out_rd         result handshake (out_vld high only in DONE)
//   busy                     high in RUN or DONE
//   out_ovf                  signed overflow flag, present only with SERIAL_ADDER_OVF_EN defined
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_ci,
    input  logic                  in_vld,
    output logic                  in_rd,
    output logic [DATA_WIDTH-1:0] out_s,
    output logic                  out_co,
    output logic                  out_vld,
    input  logic                  out_rd,
    output logic                  busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic                  out_ovf
`endif
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_next;
    // Operand A shifts out of the LSB while sum bits shift into the MSB,
    // so after DATA_WIDTH steps this register holds the full sum.
    logic [DATA_WIDTH-1:0] r_as_sh;
    logic [DATA_WIDTH-1:0] r_b_sh;
    logic [DATA_WIDTH-1:0] r_s;
    logic [CW-1:0]         r_cnt;
    logic                  r_carry;
    logic                  r_co;
    logic                  w_s;
    logic                  w_co;
    logic                  w_last;

    full_adder u_fa (
        .a  (r_as_sh[0]),
        .b  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_last = (r_state == RUN) && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && in_vld) w_next = RUN;
        else if (w_last)               w_next = DONE;
        else if (r_state == DONE && out_rd) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_as_sh <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
        end else if (r_state == IDLE && in_vld) begin
            r_as_sh <= in_a;
            r_b_sh  <= in_b;
            r_carry <= in_ci;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_as_sh <= {w_s, r_as_sh[DATA_WIDTH-1:1]};
            r_b_sh  <= r_b_sh >> 1;
            r_carry <= w_co;
            r_cnt   <= w_last ? r_cnt : r_cnt + 1'b1;
            // Result registers update only on the final bit so they keep the
            // previous answer throughout a new RUN.
            if (w_last) begin
                r_s  <= {w_s, r_as_sh[DATA_WIDTH-1:1]};
                r_co <= w_co;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the MSB step r_carry is the carry into the MSB and w_co the carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_ovf <= 1'b0;
        else if (w_last) r_ovf <= r_carry ^ w_co;
    end

    assign out_ovf = r_ovf;
`endif

    assign in_rd   = (r_state == IDLE);
    assign busy    = (r_state != IDLE);
    assign out_vld = (r_state == DONE);
    assign out_s   = r_s;
    assign out_co  = r_co;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed table-driven bench for serial_adder_ctrl at DATA_WIDTH=4.
module tb_serial_adder_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ci = 1'b0;
    logic         in_vld = 1'b0;
    logic         in_rd;
    logic [W-1:0] out_s;
    logic         out_co;
    logic         out_vld;
    logic         out_rd = 1'b1;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         out_ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    serial_adder_ctrl #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_a    (in_a),
        .in_b    (in_b),
        .in_ci   (in_ci),
        .in_vld  (in_vld),
        .in_rd   (in_rd),
        .out_s   (out_s),
        .out_co  (out_co),
        .out_vld (out_vld),
        .out_rd  (out_rd),
        .busy    (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .out_ovf (out_ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_vld counting edges since the accepting edge; returns the count.
    task automatic wait_vld(output int n);
        n = 0;
        while (!out_vld && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic do_op(input string name, input vec_t v);
        int n;
        in_a   = v.a;
        in_b   = v.b;
        in_ci  = v.ci;
        in_vld = 1'b1;
        out_rd = 1'b1;
        chk({name, "_in_rd_idle"}, 32'(in_rd), 1);
        step();
        in_vld = 1'b0;
        chk({name, "_busy_run"}, 32'(busy), 1);
        wait_vld(n);
        chk({name, "_latency"}, 32'(n), W);
        chk({name, "_s"}, 32'(out_s), 32'(v.s));
        chk({name, "_co"}, 32'(out_co), 32'(v.co));
        chk({name, "_in_rd_done"}, 32'(in_rd), 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk({name, "_ovf"}, 32'(out_ovf), 32'(v.ovf));
`endif
        step();
        chk({name, "_vld_drop"}, 32'(out_vld), 0);
        chk({name, "_s_hold"}, 32'(out_s), 32'(v.s));
    endtask

    vec_t vt[9];

    initial begin
        int n;
        int acc[3];
        logic seen;
        vt[0] = '{a: 4'd3,  b: 4'd5,  ci: 1'b0, s: 4'd8,  co: 1'b0, ovf: 1'b1};
        vt[1] = '{a: 4'd15, b: 4'd1,  ci: 1'b0, s: 4'd0,  co: 1'b1, ovf: 1'b0};
        vt[2] = '{a: 4'd15, b: 4'd15, ci: 1'b1, s: 4'd15, co: 1'b1, ovf: 1'b0};
        vt[3] = '{a: 4'd7,  b: 4'd1,  ci: 1'b0, s: 4'd8,  co: 1'b0, ovf: 1'b1};
        vt[4] = '{a: 4'd2,  b: 4'd2,  ci: 1'b0, s: 4'd4,  co: 1'b0, ovf: 1'b0};
        vt[5] = '{a: 4'd0,  b: 4'd0,  ci: 1'b1, s: 4'd1,  co: 1'b0, ovf: 1'b0};
        vt[6] = '{a: 4'd8,  b: 4'd8,  ci: 1'b0, s: 4'd0,  co: 1'b1, ovf: 1'b1};
        vt[7] = '{a: 4'd10, b: 4'd6,  ci: 1'b1, s: 4'd1,  co: 1'b1, ovf: 1'b0};
        vt[8] = '{a: 4'd9,  b: 4'd4,  ci: 1'b0, s: 4'd13, co: 1'b0, ovf: 1'b0};

        #1;
        chk("rst_in_rd", 32'(in_rd), 1);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_s", 32'(out_s), 0);
        chk("rst_out_co", 32'(out_co), 0);
        step();
        step();
        rst = 1'b0;

        // out_rd outside DONE must not disturb IDLE
        out_rd = 1'b1;
        step();
        chk("idle_out_rd_busy", 32'(busy), 0);

        for (int i = 0; i < 9; i++) do_op($sformatf("vec%0d", i), vt[i]);

        // Backpressure: DONE held for 3 cycles while a new request waits
        in_a = 4'd6; in_b = 4'd7; in_ci = 1'b0; in_vld = 1'b1; out_rd = 1'b0;
        step();
        in_a = 4'd1; in_b = 4'd1;
        wait_vld(n);
        chk("bp_latency", 32'(n), W);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_vld%0d", k), 32'(out_vld), 1);
            chk($sformatf("bp_s%0d", k), 32'(out_s), 13);
            chk($sformatf("bp_co%0d", k), 32'(out_co), 0);
            chk($sformatf("bp_in_rd%0d", k), 32'(in_rd), 0);
            step();
        end
        out_rd = 1'b1;
        step();
        chk("bp_release_idle", 32'(in_rd), 1);
        step();
        chk("bp_next_accept", 32'(busy), 1);
        in_vld = 1'b0;
        wait_vld(n);
        chk("bp_next_s", 32'(out_s), 2);
        step();

        // Reset in the second RUN cycle discards the operation
        in_a = 4'd9; in_b = 4'd9; in_ci = 1'b0; in_vld = 1'b1;
        step();
        in_vld = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_in_rd", 32'(in_rd), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_vld", 32'(out_vld), 0);
        chk("arst_s", 32'(out_s), 0);
        chk("arst_co", 32'(out_co), 0);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            step();
            if (out_vld) seen = 1'b1;
        end
        chk("arst_no_vld", 32'(seen), 0);
        do_op("arst_after", vt[4]);

        // Back-to-back with in_vld held high
        in_vld = 1'b1; out_rd = 1'b1; in_ci = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_a = 4'(k + 1);
            in_b = 4'(2 * k + 3);
            step();
            acc[k] = cyc;
            chk($sformatf("b2b_accept%0d", k), 32'(busy), 1);
            wait_vld(n);
            chk($sformatf("b2b_s%0d", k), 32'(out_s), 32'(3 * k + 4));
            if (k > 0) chk($sformatf("b2b_gap%0d", k), 32'(acc[k] - acc[k-1]), W + 2);
            step();
        end
        in_vld = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
